irq_timer_sched: RTL and testbench
==================================

Name: irq_timer_sched

Overview:
- Multi-channel timer/interrupt scheduler for the IRQ subsystem.
- One shared prescaler (sub-module tick_div) generates a base tick. NCH channel counters consume that tick.
- Channel expiries are arbitrated round-robin onto a single irq/ack interface toward the core.
- A simple synchronous register port configures the block.

Parameters:
- NCH, 4, number of timer channels (2..8)
- CW, 32, width of prescale, counter and compare registers

Ports:
- clk_in  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- cfg_we  in  1  register write strobe, one cycle per write
- cfg_addr  in  5  register address
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  combinational read of the register at cfg_addr
- irq  out  1  interrupt request, level; held until acknowledged
- irq_id  out  3  channel number presented with irq; stable while irq=1
- irq_ack  in  1  one-cycle acknowledge of the presented request

Behaviour:
- Reset: on clk_in rising edge with RESET=0, all of the following clear:
  - PRESCALE, GCTRL, all CMP/CCTRL, counters, pending and overrun bits
  - irq=0, irq_id=0, last_grant=NCH-1
- Register map:
  - 0 = PRESCALE[CW-1:0]
  - 1 = GCTRL: bit0 global enable
  - 2+2c = CMP of channel c
  - 3+2c = CCTRL of channel c: bit0 en, bit1 periodic, bit2 pending (RO), bit3 overrun (write-1-clear)
  - Unmapped reads return 0; unmapped writes are ignored.
- Prescaler (tick_div):
  - Emits a one-cycle tick when its counter reaches PRESCALE-1, then restarts at 0.
  - PRESCALE=1: tick every cycle. PRESCALE=0: no ticks.
  - Counter is forced to 0 and tick=0 while GCTRL.bit0=0 or RESET=0.
  - Any write to PRESCALE restarts the counter at 0 in the following cycle.
- Channel c, on a tick with en=1:
  - cnt==CMP-1: cnt<=0 and pending<=1. If pending was already 1, overrun<=1 (sticky). In one-shot mode (periodic=0), en<=0.
  - Otherwise cnt<=cnt+1.
  - CMP=0: channel never fires; cnt holds at 0.
  - en=0: cnt holds.
  - Writing CCTRL with en 0->1 resets cnt to 0. Writing CMP resets cnt to 0.
- Arbiter FSM, states IDLE and PRESENT:
  - IDLE: if any pending bit is set, pick the first pending channel searching from last_grant+1 (mod NCH). Register irq<=1 and irq_id<=that channel, then go to PRESENT. First irq rises one cycle after pending sets.
  - PRESENT: irq and irq_id are held. On irq_ack=1: clear pending[irq_id], set last_grant<=irq_id, set irq<=0, return to IDLE. Minimum one irq-low cycle between grants.
  - irq_ack while IDLE is ignored.
- Simultaneous events:
  - Expiry on the same cycle as the ack of that channel: set wins (pending stays 1), no overrun.
  - Disabling a channel in PRESENT does not withdraw irq; it stays until ack.
  - Register write and tick on the same cycle: the write takes effect and that channel's tick update is discarded.
- Reset mid-operation: immediate return to the reset state. A pending ack is lost.
- Counter arithmetic is unsigned CW-bit. The compare uses CMP-1 computed in CW bits. No wrap beyond CMP-1 is possible.

Decomposition:
- Shared package irq_timer_pkg holds:
  - Register address constants: ADDR_PRESCALE, ADDR_GCTRL, ADDR_CH_BASE.
  - CCTRL bit indices.
  - Arbiter state encoding: ST_IDLE, ST_PRESENT.
- Sub-module tick_div (inputs: clk_in, RESET, enable, restart, divisor[CW]; output: tick). It is instantiated once.
- Channel logic stays in a generate loop in the top.

Test Plan:
- PRESCALE=4, GCTRL=1, ch0 CMP=3 periodic: irq with irq_id=0 first rises 13 cycles after enable. Ack it; the next irq follows 12 cycles after the previous expiry.
- Ch0 and ch2 both CMP=2, PRESCALE=1, enabled on the same write: irq_id=0 first. After ack, irq low for exactly 1 cycle, then irq_id=2. The next round after both re-expire starts at ch0 again (round-robin from last_grant=2).
- Ch1 one-shot CMP=5, PRESCALE=1: exactly one irq_id=1. CCTRL1.en reads 0 after expiry; no further irq over 50 cycles.
- Ch0 periodic CMP=1, PRESCALE=1, ack withheld for 5 cycles: CCTRL0.overrun=1. Writing 1 to bit3 clears overrun. Pending is cleared only by ack.
- Pulse RESET=0 during PRESENT: next cycle irq=0, all registers read 0, and no irq reappears without reconfiguration.
- PRESCALE=0 with channels enabled: no irq within 100 cycles. Writing PRESCALE=2 starts ticks 2 cycles later.

Source files
------------

// File: rtl/irq_timer_pkg.sv
// Purpose: shared constants for irq_timer_sched (register map, CCTRL bit positions, arbiter states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_timer_pkg;

  localparam logic [4:0] ADDR_PRESCALE = 5'd0;
  localparam logic [4:0] ADDR_GCTRL    = 5'd1;
  localparam int         ADDR_CH_BASE  = 2;

  // CCTRL bit positions
  localparam int CC_EN   = 0;
  localparam int CC_PER  = 1;
  localparam int CC_PEND = 2;
  localparam int CC_OVR  = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_t;

  // Channel c owns CMP at base+2c (off=0) and CCTRL at base+2c+1 (off=1).
  function automatic logic [4:0] ch_addr(input int c, input int off);
    return 5'(ADDR_CH_BASE + 2 * c + off);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Purpose: shared prescaler; one-cycle tick each time the count reaches divisor-1.
// Latency: first tick divisor cycles after enable/restart; tick is combinational from the count.
// Backpressure: none; ticks are never stalled.
// Ports: clk_in, RESET (sync, active-low), enable (global enable), restart (divisor being written),
//        divisor[CW] (0 = no ticks), tick (one-cycle pulse).
module tick_div #(
  parameter int CW = 32
) (
  input  logic          clk_in,
  input  logic          RESET,
  input  logic          enable,
  input  logic          restart,
  input  logic [CW-1:0] divisor,
  output logic          tick
);

  logic [CW-1:0] cnt;

  assign tick = RESET && enable && (divisor != '0) && (cnt == divisor - CW'(1));

  always_ff @(posedge clk_in) begin
    if (!RESET || !enable || restart || divisor == '0) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/irq_timer_sched.sv
// Purpose: NCH timer channels on a shared prescaler, expiries arbitrated round-robin onto one irq/ack.
// Latency: irq rises one cycle after a pending bit sets; at least one irq-low cycle between grants.
// Backpressure: irq is held until irq_ack; expiries meanwhile accumulate as pending/overrun bits.
// Ports: clk_in, RESET (sync, active-low), cfg_we/cfg_addr/cfg_wdata (register write),
//        cfg_rdata (combinational read), irq/irq_id (request, held), irq_ack (one-cycle acknowledge).
module irq_timer_sched
  import irq_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        irq,
  output logic [2:0]  irq_id,
  input  logic        irq_ack
);

  logic [CW-1:0]  prescale;
  logic           glb_en;
  logic           prescale_wr;
  logic           tick;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] ack_clr;
  logic [31:0]    cmp_rd   [NCH];
  logic [31:0]    cctrl_rd [NCH];

  // ---------------- global registers ----------------
  assign prescale_wr = cfg_we && (cfg_addr == ADDR_PRESCALE);

  always_ff @(posedge clk_in) begin
    if (!RESET) begin
      prescale <= '0;
      glb_en   <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_PRESCALE) prescale <= cfg_wdata[CW-1:0];
      if (cfg_addr == ADDR_GCTRL)    glb_en   <= cfg_wdata[0];
    end
  end

  tick_div #(.CW(CW)) u_tick_div (
    .clk_in  (clk_in),
    .RESET   (RESET),
    .enable  (glb_en),
    .restart (prescale_wr),
    .divisor (prescale),
    .tick    (tick)
  );

  // ---------------- channels ----------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [4:0] A_CMP   = ch_addr(c, 0);
    localparam logic [4:0] A_CCTRL = ch_addr(c, 1);

    logic [CW-1:0] cmp_q, cnt_q;
    logic          en_q, per_q, pend_q, ovr_q;
    logic          wr_cmp, wr_cctrl, adv, hit, expire;

    assign wr_cmp   = cfg_we && (cfg_addr == A_CMP);
    assign wr_cctrl = cfg_we && (cfg_addr == A_CCTRL);
    assign adv      = tick && en_q && (cmp_q != '0);
    assign hit      = (cnt_q == cmp_q - CW'(1));
    // A register write to this channel swallows its tick update, expiry included.
    assign expire   = adv && hit && !wr_cmp && !wr_cctrl;

    always_ff @(posedge clk_in) begin
      if (!RESET) begin
        cmp_q  <= '0;
        cnt_q  <= '0;
        en_q   <= 1'b0;
        per_q  <= 1'b0;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (wr_cmp) begin
          cmp_q <= cfg_wdata[CW-1:0];
          cnt_q <= '0;
        end else if (wr_cctrl) begin
          en_q  <= cfg_wdata[CC_EN];
          per_q <= cfg_wdata[CC_PER];
          if (cfg_wdata[CC_OVR])            ovr_q <= 1'b0;
          if (!en_q && cfg_wdata[CC_EN])    cnt_q <= '0;
        end else if (adv) begin
          if (hit) begin
            cnt_q <= '0;
            // An expiry landing on the ack of the same channel is not an overrun.
            if (pend_q && !ack_clr[c]) ovr_q <= 1'b1;
            if (!per_q)                en_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // Set beats clear when expiry and ack coincide.
        if (expire)          pend_q <= 1'b1;
        else if (ack_clr[c]) pend_q <= 1'b0;
      end
    end

    assign pend[c]     = pend_q;
    assign cmp_rd[c]   = 32'(cmp_q);
    // Bit order follows CC_EN/CC_PER/CC_PEND/CC_OVR = 0..3.
    assign cctrl_rd[c] = {28'b0, ovr_q, pend_q, per_q, en_q};
  end

  // ---------------- register read ----------------
  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr == ADDR_PRESCALE) cfg_rdata = 32'(prescale);
    if (cfg_addr == ADDR_GCTRL)    cfg_rdata = {31'b0, glb_en};
    for (int c = 0; c < NCH; c++) begin
      if (cfg_addr == ch_addr(c, 0)) cfg_rdata = cmp_rd[c];
      if (cfg_addr == ch_addr(c, 1)) cfg_rdata = cctrl_rd[c];
    end
  end

  // ---------------- round-robin arbiter ----------------
  arb_state_t state, state_nxt;
  logic       irq_nxt;
  logic [2:0] id_nxt, last_grant, lg_nxt, pick;
  logic       found;
  int         idx;

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    id_nxt    = irq_id;
    lg_nxt    = last_grant;
    ack_clr   = '0;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;
    case (state)
      ST_IDLE: begin
        // Search starts just after the last granted channel, wrapping at NCH.
        for (int i = 1; i <= NCH; i++) begin
          idx = int'(last_grant) + i;
          if (idx >= NCH) idx = idx - NCH;
          for (int c = 0; c < NCH; c++) begin
            if (!found && c == idx && pend[c]) begin
              found = 1'b1;
              pick  = 3'(c);
            end
          end
        end
        if (found) begin
          irq_nxt   = 1'b1;
          id_nxt    = pick;
          state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (irq_ack) begin
          for (int c = 0; c < NCH; c++) begin
            if (irq_id == 3'(c)) ack_clr[c] = 1'b1;
          end
          lg_nxt    = irq_id;
          irq_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      last_grant <= 3'(NCH - 1);
    end else begin
      state      <= state_nxt;
      irq        <= irq_nxt;
      irq_id     <= id_nxt;
      last_grant <= lg_nxt;
    end
  end

endmodule

// File: tb/tb_irq_timer_sched.sv
module tb_irq_timer_sched;

  localparam int NCH = 4;
  localparam int CW  = 32;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic [2:0]  irq_id;
  logic        irq_ack = 1'b0;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  always #5 clk_in = ~clk_in;

  irq_timer_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk_in    (clk_in),
    .RESET     (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq       (irq),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  // ---------------- reference model ----------------
  longint m_pre, m_phase;
  bit     m_gen;
  longint m_cmp [NCH];
  longint m_cnt [NCH];
  bit     m_en [NCH], m_per [NCH], m_pend [NCH], m_ovr [NCH];
  bit     m_irq, m_busy, started;
  int     m_id, m_lg;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_model(input int a);
    int c;
    if (a == 0) return 32'(m_pre);
    if (a == 1) return {31'b0, m_gen};
    if (a >= 2 && a < 2 + 2 * NCH) begin
      c = (a - 2) / 2;
      if ((a - 2) % 2 == 0) return 32'(m_cmp[c]);
      return {28'b0, m_ovr[c], m_pend[c], m_per[c], m_en[c]};
    end
    return 32'h0;
  endfunction

  task automatic model_step();
    bit tick, wr;
    bit ackc [NCH];
    bit expv [NCH];
    int a, c, pick;
    a = int'(cfg_addr);
    if (!reset_n) begin
      m_pre = 0; m_phase = 0; m_gen = 0;
      for (int k = 0; k < NCH; k++) begin
        m_cmp[k] = 0; m_cnt[k] = 0; m_en[k] = 0; m_per[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
      end
      m_irq = 0; m_busy = 0; m_id = 0; m_lg = NCH - 1;
      started = 1;
      return;
    end
    // prescaler: a tick every m_pre cycles since the last (re)start
    tick = m_gen && (m_pre != 0) && (m_phase % m_pre == m_pre - 1);
    if (!m_gen || m_pre == 0 || (cfg_we && a == 0)) m_phase = 0;
    else m_phase++;
    for (int k = 0; k < NCH; k++) begin
      ackc[k] = m_busy && irq_ack && (m_id == k);
      expv[k] = 0;
    end
    for (int k = 0; k < NCH; k++) begin
      wr = cfg_we && (a == 2 + 2 * k || a == 3 + 2 * k);
      if (tick && m_en[k] && m_cmp[k] != 0 && !wr) begin
        if (m_cnt[k] + 1 == m_cmp[k]) begin
          expv[k] = 1;
          m_cnt[k] = 0;
          if (m_pend[k] && !ackc[k]) m_ovr[k] = 1;
          if (!m_per[k]) m_en[k] = 0;
        end else begin
          m_cnt[k]++;
        end
      end
    end
    if (!m_busy) begin
      pick = -1;
      for (int i = 1; i <= NCH; i++) begin
        c = (m_lg + i) % NCH;
        if (pick < 0 && m_pend[c]) pick = c;
      end
      if (pick >= 0) begin
        m_busy = 1; m_irq = 1; m_id = pick;
      end
    end else if (irq_ack) begin
      m_busy = 0; m_irq = 0; m_lg = m_id;
    end
    for (int k = 0; k < NCH; k++) m_pend[k] = (m_pend[k] && !ackc[k]) || expv[k];
    if (cfg_we) begin
      if (a == 0) m_pre = longint'(cfg_wdata);
      else if (a == 1) m_gen = cfg_wdata[0];
      else if (a >= 2 && a < 2 + 2 * NCH) begin
        c = (a - 2) / 2;
        if ((a - 2) % 2 == 0) begin
          m_cmp[c] = longint'(cfg_wdata);
          m_cnt[c] = 0;
        end else begin
          if (!m_en[c] && cfg_wdata[0]) m_cnt[c] = 0;
          m_en[c]  = cfg_wdata[0];
          m_per[c] = cfg_wdata[1];
          if (cfg_wdata[3]) m_ovr[c] = 0;
        end
      end
    end
  endtask

  always @(posedge clk_in) begin
    cyc++;
    model_step();
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk_in) begin
    if (started) begin
      chk("irq", longint'(irq), longint'(m_irq));
      chk("irq_id", longint'(irq_id), longint'(m_id));
      chk("cfg_rdata", longint'(cfg_rdata), longint'(rd_model(int'(cfg_addr))));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    cfg_we = 0; irq_ack = 0; reset_n = 0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    reset_n = 1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cfg_we = 1; cfg_addr = 5'(a); cfg_wdata = d;
    @(posedge clk_in); #1;
    cfg_we = 0;
  endtask

  task automatic rd(input string name, input int a, input logic [31:0] exp);
    cfg_addr = 5'(a);
    #2;
    chk(name, longint'(cfg_rdata), longint'(exp));
    @(posedge clk_in); #1;
  endtask

  task automatic ack();
    irq_ack = 1;
    @(posedge clk_in); #1;
    irq_ack = 0;
  endtask

  task automatic wait_irq(input string name, input int max, output int n);
    n = 0;
    while (!irq && n < max) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk(name, longint'(irq), 1);
  endtask

  int     n, hits, seen_id;
  longint r1, r2;

  initial begin
    #1;
    do_reset();
    rd("reset_gctrl", 1, 32'h0);
    chk("reset_irq", longint'(irq), 0);

    // 1: prescale 4, ch0 CMP=3 periodic
    wr(2, 3); wr(3, 3); wr(0, 4); wr(1, 1);
    wait_irq("t1_irq1", 40, n);
    chk("t1_first_latency", n, 13);
    chk("t1_id", longint'(irq_id), 0);
    r1 = cyc;
    ack();
    wait_irq("t1_irq2", 40, n);
    r2 = cyc;
    chk("t1_period", r2 - r1, 12);
    ack();

    // 2: ch0 and ch2 expire together, round-robin order
    do_reset();
    wr(2, 2); wr(6, 2); wr(3, 3); wr(7, 3); wr(0, 1); wr(1, 1);
    wait_irq("t2_irq1", 20, n);
    chk("t2_latency", n, 3);
    chk("t2_first_id", longint'(irq_id), 0);
    ack();
    chk("t2_gap_low", longint'(irq), 0);
    @(posedge clk_in); #1;
    chk("t2_second_irq", longint'(irq), 1);
    chk("t2_second_id", longint'(irq_id), 2);
    ack();
    wait_irq("t2_irq3", 20, n);
    chk("t2_wrap_id", longint'(irq_id), 0);
    ack();

    // 3: one-shot ch1
    do_reset();
    wr(4, 5); wr(5, 1); wr(0, 1); wr(1, 1);
    hits = 0; seen_id = -1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk_in); #1;
      if (irq && !irq_ack) begin
        hits++; seen_id = int'(irq_id); irq_ack = 1;
      end else begin
        irq_ack = 0;
      end
    end
    irq_ack = 0;
    chk("t3_irq_count", hits, 1);
    chk("t3_id", seen_id, 1);
    rd("t3_cctrl1", 5, 32'h0);

    // 4: overrun while ack is withheld
    do_reset();
    wr(2, 1); wr(3, 3); wr(0, 1); wr(1, 1);
    wait_irq("t4_irq", 20, n);
    repeat (5) begin @(posedge clk_in); #1; end
    rd("t4_overrun_set", 3, 32'hF);
    wr(3, 0);
    rd("t4_pend_kept", 3, 32'hC);
    chk("t4_irq_held", longint'(irq), 1);
    ack();
    rd("t4_pend_acked", 3, 32'h8);
    wr(3, 8);
    rd("t4_ovr_cleared", 3, 32'h0);

    // 6: PRESCALE=0 stalls everything, then start ticking
    do_reset();
    wr(2, 1); wr(3, 3); wr(0, 0); wr(1, 1);
    hits = 0;
    repeat (100) begin @(posedge clk_in); #1; if (irq) hits++; end
    chk("t6_no_irq", hits, 0);
    wr(0, 2);
    wait_irq("t6_irq", 10, n);
    chk("t6_latency", n, 3);

    // 5: reset while presenting
    reset_n = 0;
    @(posedge clk_in); #1;
    reset_n = 1;
    chk("t5_irq_low", longint'(irq), 0);
    chk("t5_id_zero", longint'(irq_id), 0);
    for (int a = 0; a < 2 + 2 * NCH; a++) rd("t5_reg_zero", a, 32'h0);
    hits = 0;
    repeat (50) begin @(posedge clk_in); #1; if (irq) hits++; end
    chk("t5_quiet", hits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
